// File: rtl/regfile_dump.sv
// Debug read-out engine: walks x0..x(NUM_REGS-1) through a dedicated read port,
// streams each value with its index over valid/ready, and reports an XOR checksum.
module regfile_dump #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 32
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  START,
  input  logic                  ABORT,
  output logic [ADDR_WIDTH-1:0] RS_SEL,
  input  logic [DATA_WIDTH-1:0] RS_DOUT,
  output logic                  OUT_VALID,
  input  logic                  OUT_READY,
  output logic [DATA_WIDTH-1:0] OUT_DATA,
  output logic [ADDR_WIDTH-1:0] OUT_IDX,
  output logic                  OUT_LAST,
  output logic                  BUSY,
  output logic                  DONE,
  output logic [DATA_WIDTH-1:0] CHECKSUM
);

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_REGS - 1);

  typedef enum logic [1:0] {IDLE, FETCH, SEND, FINISH} state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   idx_q, idx_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic [ADDR_WIDTH-1:0]   oidx_q, oidx_d;
  logic                    last_q, last_d;
  logic [DATA_WIDTH-1:0]   csum_q, csum_d;
  logic                    hs;

  // A handshake that coincides with ABORT is discarded.
  assign hs = (state_q == SEND) && OUT_READY && !ABORT;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      idx_q   <= '0;
      data_q  <= '0;
      oidx_q  <= '0;
      last_q  <= 1'b0;
      csum_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      oidx_q  <= oidx_d;
      last_q  <= last_d;
      csum_q  <= csum_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (START) state_d = FETCH;
      FETCH:   state_d = ABORT ? IDLE : SEND;
      SEND: begin
        if (ABORT)   state_d = IDLE;
        else if (hs) state_d = last_q ? FINISH : FETCH;
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    idx_d  = idx_q;
    data_d = data_q;
    oidx_d = oidx_q;
    last_d = last_q;
    csum_d = csum_q;
    if (state_q == IDLE && START) begin
      idx_d  = '0;
      csum_d = '0;
    end
    if (state_q == FETCH) begin
      data_d = RS_DOUT;
      oidx_d = idx_q;
      last_d = (idx_q == LAST_IDX);
    end
    if (hs) begin
      csum_d = csum_q ^ data_q;
      if (!last_q) idx_d = idx_q + 1'b1;
    end
  end

  // idx_q only advances on leaving SEND, so it still names the last fetch in SEND/FINISH.
  always_comb begin
    RS_SEL    = (state_q == IDLE) ? '0 : idx_q;
    OUT_VALID = (state_q == SEND);
    BUSY      = (state_q != IDLE);
    DONE      = (state_q == FINISH);
  end

  assign OUT_DATA = data_q;
  assign OUT_IDX  = oidx_q;
  assign OUT_LAST = last_q;
  assign CHECKSUM = csum_q;

endmodule

// File: tb/tb_regfile_dump.sv
// Directed bench for regfile_dump: table of dump scenarios plus reset-mid-dump sequence.
module tb_regfile_dump;

  logic        CLK = 1'b0;
  logic        RESET, START, ABORT, OUT_READY;
  logic [4:0]  RS_SEL, OUT_IDX;
  logic [31:0] RS_DOUT, OUT_DATA, CHECKSUM;
  logic        OUT_VALID, OUT_LAST, BUSY, DONE;

  logic [31:0] rf [0:31];
  int nvec = 0;
  int nerr = 0;

  always #5 CLK = ~CLK;

  assign RS_DOUT = (RS_SEL == 5'd0) ? 32'd0 : rf[RS_SEL];

  regfile_dump dut (
    .CLK(CLK), .RESET(RESET), .START(START), .ABORT(ABORT),
    .RS_SEL(RS_SEL), .RS_DOUT(RS_DOUT),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_DATA(OUT_DATA),
    .OUT_IDX(OUT_IDX), .OUT_LAST(OUT_LAST), .BUSY(BUSY), .DONE(DONE),
    .CHECKSUM(CHECKSUM)
  );

  typedef struct {
    string       name;
    int          fill;       // 0: x2/x3 pattern, 1: 0xA5A50000+i
    int          rdy;        // 1: held high, 0: pseudo-random
    int          abort_idx;  // -1: none
    bit          pulses;
    bit          cwrite;
    int          exp_words;
    logic [31:0] exp_csum;
    int          exp_done;   // cycle of DONE, -1: not timed
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic fill(input int mode);
    for (int i = 0; i < 32; i++) rf[i] = (mode == 0) ? 32'd0 : 32'hA5A50000 + 32'(i);
    if (mode == 0) begin
      rf[2] = 32'h01000000;
      rf[3] = 32'h02000000;
    end
  endtask

  task automatic run_dump(input vec_t v);
    int c, words, exp_idx, dones;
    bit ended, rdy, ab, hs, stall;
    logic [31:0] pdata, exp_data;
    logic [4:0]  pidx;
    fill(v.fill);
    START = 1'b1; ABORT = 1'b0; OUT_READY = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0; c = 1;
    chk($sformatf("%s busy@1", v.name), 32'(BUSY), 32'd1);
    chk($sformatf("%s valid@1", v.name), 32'(OUT_VALID), 32'd0);
    words = 0; exp_idx = 0; dones = 0; ended = 1'b0; stall = 1'b0;
    pdata = '0; pidx = '0;
    while (!ended && c < 1000) begin
      if (stall) begin
        chk($sformatf("%s stall valid", v.name), 32'(OUT_VALID), 32'd1);
        chk($sformatf("%s stall data", v.name), OUT_DATA, pdata);
        chk($sformatf("%s stall idx", v.name), 32'(OUT_IDX), 32'(pidx));
      end
      rdy = (v.rdy == 1) ? 1'b1 : 1'($urandom_range(0, 1));
      ab  = (v.abort_idx >= 0) && OUT_VALID && (int'(OUT_IDX) == v.abort_idx);
      if (v.cwrite && OUT_VALID && OUT_IDX == 5'd3) rf[5] = 32'hDEADBEEF;
      START     = v.pulses && (c == 5 || c == 20 || c == 40);
      OUT_READY = rdy;
      ABORT     = ab;
      hs = OUT_VALID && rdy && !ab;
      if (hs) begin
        exp_data = (exp_idx == 0) ? 32'd0 : rf[exp_idx];
        chk($sformatf("%s idx", v.name), 32'(OUT_IDX), 32'(exp_idx));
        chk($sformatf("%s data[%0d]", v.name, exp_idx), OUT_DATA, exp_data);
        chk($sformatf("%s last[%0d]", v.name, exp_idx), 32'(OUT_LAST), 32'(exp_idx == 31));
        if (v.cwrite && exp_idx == 5) chk($sformatf("%s word5", v.name), OUT_DATA, 32'hDEADBEEF);
        exp_idx++; words++;
      end
      if (DONE) begin
        dones++;
        chk($sformatf("%s csum@done", v.name), CHECKSUM, v.exp_csum);
        if (v.exp_done > 0) chk($sformatf("%s done cycle", v.name), 32'(c), 32'(v.exp_done));
      end
      stall = OUT_VALID && !rdy && !ab;
      pdata = OUT_DATA; pidx = OUT_IDX;
      @(posedge CLK); #1;
      c++;
      if (ab) begin
        chk($sformatf("%s abort valid", v.name), 32'(OUT_VALID), 32'd0);
        chk($sformatf("%s abort busy", v.name), 32'(BUSY), 32'd0);
      end
      if (!BUSY) ended = 1'b1;
    end
    START = 1'b0; ABORT = 1'b0; OUT_READY = 1'b1;
    if (!ended) chk($sformatf("%s timeout", v.name), 32'd0, 32'd1);
    if (v.exp_done > 0) chk($sformatf("%s idle cycle", v.name), 32'(c), 32'(v.exp_done + 1));
    chk($sformatf("%s words", v.name), 32'(words), 32'(v.exp_words));
    chk($sformatf("%s dones", v.name), 32'(dones), (v.abort_idx < 0) ? 32'd1 : 32'd0);
    chk($sformatf("%s csum hold", v.name), CHECKSUM, v.exp_csum);
    chk($sformatf("%s idle rs_sel", v.name), 32'(RS_SEL), 32'd0);
    chk($sformatf("%s idle valid", v.name), 32'(OUT_VALID), 32'd0);
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk({nm, " rs_sel"}, 32'(RS_SEL), 32'd0);
    chk({nm, " valid"}, 32'(OUT_VALID), 32'd0);
    chk({nm, " data"}, OUT_DATA, 32'd0);
    chk({nm, " idx"}, 32'(OUT_IDX), 32'd0);
    chk({nm, " last"}, 32'(OUT_LAST), 32'd0);
    chk({nm, " busy"}, 32'(BUSY), 32'd0);
    chk({nm, " done"}, 32'(DONE), 32'd0);
    chk({nm, " csum"}, CHECKSUM, 32'd0);
  endtask

  initial begin
    int n;
    vec_t post;
    // x0 reads 0, so the A5A5 pattern XORs over x1..x31 only.
    vecs[0] = '{"basic",   0, 1, -1, 1'b0, 1'b0, 32, 32'h03000000, 65};
    vecs[1] = '{"bp",      1, 0, -1, 1'b0, 1'b0, 32, 32'hA5A50000, -1};
    vecs[2] = '{"abort10", 1, 1, 10, 1'b0, 1'b0, 10, 32'hA5A50001, -1};
    vecs[3] = '{"pulses",  1, 1, -1, 1'b1, 1'b0, 32, 32'hA5A50000, 65};
    vecs[4] = '{"cwrite",  1, 1, -1, 1'b0, 1'b1, 32, 32'hDEADBEEA, 65};

    fill(0);
    RESET = 1'b1; START = 1'b0; ABORT = 1'b0; OUT_READY = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    chk_reset_outputs("reset");
    RESET = 1'b0;
    @(posedge CLK); #1;

    foreach (vecs[i]) begin
      run_dump(vecs[i]);
      repeat (2) @(posedge CLK);
      #1;
    end

    // Reset while idx 17 is on the output, then a clean dump from idx 0.
    fill(1);
    START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    n = 0;
    while (!(OUT_VALID && OUT_IDX == 5'd17) && n < 200) begin
      @(posedge CLK); #1;
      n++;
    end
    if (n >= 200) chk("rst17 reach", 32'd0, 32'd1);
    RESET = 1'b1;
    @(posedge CLK); #1;
    chk_reset_outputs("rst17");
    RESET = 1'b0;
    @(posedge CLK); #1;
    post = '{"after_rst", 1, 1, -1, 1'b0, 1'b0, 32, 32'hA5A50000, 65};
    run_dump(post);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
